// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
//   state_t        : two-state access FSM encoding (IDLE, ACCESS)
//   ALIGN_MASK     : low address bits that must be zero for a 64-bit access
//   is_misaligned  : helper applying ALIGN_MASK to the low address bits
package mem_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [2:0] ALIGN_MASK = 3'b111;

  function automatic logic is_misaligned(input logic [2:0] addr_lsb);
    return |(addr_lsb & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/memory_access_flopre.sv
// flopre: N-bit register with synchronous active-high reset and load enable.
//   clk   : clock
//   reset : synchronous reset, clears q to 0 (has priority over en)
//   en    : load enable
//   d     : data in
//   q     : registered data out
module flopre #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_access.sv
// memory_access: M pipeline stage. Captures the execute-stage result, performs
// an optional data-memory load/store handshake and presents the M results.
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   valid_E + *_E              : execute-stage result and control (held by
//                                upstream while stall_E is high)
//   stall_E                    : high exactly while a memory access is pending
//   valid_M                    : one-cycle pulse, M outputs valid
//   aluResult_M, readData_M,
//   PCBranch_M, PCSrc_M        : stage results
//   misalign_M                 : misaligned memory op flag (only when the
//                                MEM_ALIGN_CHECK_EN macro is defined)
//   mem_req/we/addr/wdata      : data memory request, held until mem_ready
//   mem_ready, mem_rdata       : memory completion and load data
//
// Build option: define MEM_ALIGN_CHECK_EN to reject memory ops whose address
// has any of the low three bits set (reported through misalign_M instead of
// touching memory).
module memory_access
  import mem_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic         zero_E,
  input  logic         Branch_E,
  input  logic         memRead_E,
  input  logic         memWrite_E,
  output logic         stall_E,
  output logic         valid_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] readData_M,
  output logic [N-1:0] PCBranch_M,
  output logic         PCSrc_M,
`ifdef MEM_ALIGN_CHECK_EN
  output logic         misalign_M,
`endif
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata
);

  state_t     state_reg, state_next;
  logic       valid_reg, valid_next;
  logic       capture;
  logic       mem_op_E;
  logic       misalign_E;
  logic       access_done;
  logic       load_done;
  logic [N-1:0] writeData_M;

  // Control bits captured alongside the data fields: {zero, branch, read, write}
  logic [3:0] ctrl_E;
  logic [3:0] ctrl_M;
  logic       zero_M, branch_M, read_M, write_M;

  assign capture     = (state_reg == IDLE) && valid_E;
  assign mem_op_E    = memRead_E | memWrite_E;
  assign access_done = (state_reg == ACCESS) && mem_ready;
  // A read+write op is treated as a write, so only pure loads update readData_M.
  assign load_done   = access_done && read_M && !write_M;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_E = mem_op_E && is_misaligned(aluResult_E[2:0]);
`else
  assign misalign_E = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (capture) begin
          if (mem_op_E && !misalign_E) begin
            state_next = ACCESS;
          end else begin
            // ALU-only or rejected op: result is ready next cycle.
            valid_next = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_next = IDLE;
          valid_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_reg;
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= capture && misalign_E;
    end
  end
  assign misalign_M = misalign_reg;
`endif

  // ---------------------------------------------------------- M registers
  flopre #(.N(N)) u_alu_result (
    .clk(clk), .reset(reset), .en(capture), .d(aluResult_E), .q(aluResult_M)
  );

  flopre #(.N(N)) u_write_data (
    .clk(clk), .reset(reset), .en(capture), .d(writeData_E), .q(writeData_M)
  );

  flopre #(.N(N)) u_pc_branch (
    .clk(clk), .reset(reset), .en(capture), .d(PCBranch_E), .q(PCBranch_M)
  );

  flopre #(.N(N)) u_read_data (
    .clk(clk), .reset(reset), .en(load_done), .d(mem_rdata), .q(readData_M)
  );

  assign ctrl_E = {zero_E, Branch_E, memRead_E, memWrite_E};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ctrl
      flopre #(.N(1)) u_ctrl (
        .clk(clk), .reset(reset), .en(capture), .d(ctrl_E[gi]), .q(ctrl_M[gi])
      );
    end
  endgenerate

  assign {zero_M, branch_M, read_M, write_M} = ctrl_M;

  // -------------------------------------------------------------- outputs
  assign stall_E   = (state_reg == ACCESS);
  assign valid_M   = valid_reg;
  assign PCSrc_M   = valid_reg && branch_M && zero_M;
  assign mem_req   = (state_reg == ACCESS);
  assign mem_we    = (state_reg == ACCESS) && write_M;
  assign mem_addr  = aluResult_M;
  assign mem_wdata = writeData_M;

endmodule

// File: tb/tb_memory_access.sv
// Directed, table-driven bench for memory_access: single-cycle ALU/branch ops
// from a vector table, plus hand sequences for loads, stores, read+write,
// reset during an access and (when built with MEM_ALIGN_CHECK_EN) misalignment.
module tb_memory_access;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_E;
  logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
  logic         zero_E, Branch_E, memRead_E, memWrite_E;
  logic         stall_E, valid_M, PCSrc_M;
  logic [N-1:0] aluResult_M, readData_M, PCBranch_M;
  logic         mem_req, mem_we, mem_ready;
  logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ALIGN_CHECK_EN
  logic         misalign_M;
`endif

  always #5 clk = ~clk;

  memory_access #(.N(N)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .PCBranch_E(PCBranch_E),
    .zero_E(zero_E), .Branch_E(Branch_E), .memRead_E(memRead_E), .memWrite_E(memWrite_E),
    .stall_E(stall_E), .valid_M(valid_M),
    .aluResult_M(aluResult_M), .readData_M(readData_M), .PCBranch_M(PCBranch_M),
    .PCSrc_M(PCSrc_M),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_M(misalign_M),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] alu, input logic [N-1:0] wd,
                       input logic [N-1:0] pcb, input logic z, input logic br,
                       input logic rd, input logic wr);
    valid_E = v; aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb;
    zero_E = z; Branch_E = br; memRead_E = rd; memWrite_E = wr;
  endtask

  typedef struct {
    logic [N-1:0] alu;
    logic [N-1:0] pcb;
    logic         zero;
    logic         br;
    logic         exp_pcsrc;
  } vec_t;

  vec_t vecs[4];
  int   stall_cycles;

  initial begin
    vecs[0] = '{alu: 64'h10, pcb: 64'h0,  zero: 1'b0, br: 1'b0, exp_pcsrc: 1'b0};
    vecs[1] = '{alu: 64'h20, pcb: 64'h40, zero: 1'b1, br: 1'b1, exp_pcsrc: 1'b1};
    vecs[2] = '{alu: 64'h24, pcb: 64'h40, zero: 1'b0, br: 1'b1, exp_pcsrc: 1'b0};
    vecs[3] = '{alu: 64'h0,  pcb: 64'h80, zero: 1'b1, br: 1'b0, exp_pcsrc: 1'b0};

    reset = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    // mem_ready/mem_rdata active while IDLE must be ignored.
    mem_ready = 1'b1;
    mem_rdata = 64'hDEAD;

    // ---- reset state
    tick(); tick();
    check("rst_stall", {63'b0, stall_E}, 64'd0);
    check("rst_valid", {63'b0, valid_M}, 64'd0);
    check("rst_pcsrc", {63'b0, PCSrc_M}, 64'd0);
    check("rst_req",   {63'b0, mem_req}, 64'd0);
    check("rst_we",    {63'b0, mem_we},  64'd0);
    check("rst_alu",   aluResult_M, 64'd0);
    check("rst_rdata", readData_M,  64'd0);
    check("rst_pcb",   PCBranch_M,  64'd0);
    reset = 1'b0;
    tick();

    // ---- single-cycle ALU / branch vectors
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vecs[i].alu, 64'h5A5A, vecs[i].pcb, vecs[i].zero, vecs[i].br, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("v%0d_valid", i), {63'b0, valid_M}, 64'd1);
      check($sformatf("v%0d_alu", i),   aluResult_M, vecs[i].alu);
      check($sformatf("v%0d_pcb", i),   PCBranch_M, vecs[i].pcb);
      check($sformatf("v%0d_pcsrc", i), {63'b0, PCSrc_M}, {63'b0, vecs[i].exp_pcsrc});
      check($sformatf("v%0d_stall", i), {63'b0, stall_E}, 64'd0);
      check($sformatf("v%0d_req", i),   {63'b0, mem_req}, 64'd0);
      check($sformatf("v%0d_rdata", i), readData_M, 64'd0);
`ifdef MEM_ALIGN_CHECK_EN
      check($sformatf("v%0d_mis", i), {63'b0, misalign_M}, 64'd0);
`endif
      tick();
      check($sformatf("v%0d_pulse", i), {63'b0, valid_M}, 64'd0);
      check($sformatf("v%0d_pcsrc0", i), {63'b0, PCSrc_M}, 64'd0);
      check($sformatf("v%0d_req2", i), {63'b0, mem_req}, 64'd0);
      $display("vector %0d alu=0x%0h pcb=0x%0h pcsrc=%0d", i, vecs[i].alu, vecs[i].pcb,
               vecs[i].exp_pcsrc);
    end

    // ---- load at 0x20, mem_ready tied high
    mem_rdata = 64'hCAFE;
    drive(1'b1, 64'h20, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ld_req",   {63'b0, mem_req}, 64'd1);
    check("ld_we",    {63'b0, mem_we},  64'd0);
    check("ld_addr",  mem_addr, 64'h20);
    check("ld_stall", {63'b0, stall_E}, 64'd1);
    check("ld_valid_early", {63'b0, valid_M}, 64'd0);
    tick();
    check("ld_valid", {63'b0, valid_M}, 64'd1);
    check("ld_rdata", readData_M, 64'hCAFE);
    check("ld_req_off", {63'b0, mem_req}, 64'd0);
    check("ld_stall_off", {63'b0, stall_E}, 64'd0);
    tick();
    check("ld_pulse", {63'b0, valid_M}, 64'd0);
    $display("load addr=0x20 rdata=0x%0h", readData_M);

    // ---- store 0x1234 at 0x8, ready after 3 wait cycles; valid_E during ACCESS ignored
    mem_ready = 1'b0;
    mem_rdata = 64'hBAD0;
    drive(1'b1, 64'h8, 64'h1234, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    stall_cycles = 0;
    for (int w = 0; w < 4; w++) begin
      if (w < 3) drive(1'b1, 64'h999, 64'h7777, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      else       drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (w == 3) mem_ready = 1'b1;
      if (stall_E) stall_cycles++;
      check($sformatf("st_req_%0d", w),   {63'b0, mem_req}, 64'd1);
      check($sformatf("st_we_%0d", w),    {63'b0, mem_we},  64'd1);
      check($sformatf("st_wdata_%0d", w), mem_wdata, 64'h1234);
      check($sformatf("st_addr_%0d", w),  mem_addr, 64'h8);
      tick();
    end
    check("st_stall_cycles", 64'(stall_cycles), 64'd4);
    check("st_valid", {63'b0, valid_M}, 64'd1);
    check("st_rdata", readData_M, 64'hCAFE);
    check("st_alu_kept", aluResult_M, 64'h8);
    check("st_stall_off", {63'b0, stall_E}, 64'd0);
    tick();
    check("st_pulse", {63'b0, valid_M}, 64'd0);
    $display("store addr=0x8 wdata=0x1234 stall_cycles=%0d", stall_cycles);

    // ---- read+write together behaves as a write
    mem_rdata = 64'hBEEF;
    drive(1'b1, 64'h18, 64'h55, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rw_we", {63'b0, mem_we}, 64'd1);
    check("rw_wdata", mem_wdata, 64'h55);
    tick();
    check("rw_valid", {63'b0, valid_M}, 64'd1);
    check("rw_rdata", readData_M, 64'hCAFE);
    tick();
    $display("read+write addr=0x18 readData_M=0x%0h", readData_M);

    // ---- reset during the second ACCESS cycle
    mem_ready = 1'b0;
    drive(1'b1, 64'h30, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ra_req1", {63'b0, mem_req}, 64'd1);
    tick();
    check("ra_req2", {63'b0, mem_req}, 64'd1);
    reset = 1'b1;
    tick();
    check("ra_req", {63'b0, mem_req}, 64'd0);
    check("ra_stall", {63'b0, stall_E}, 64'd0);
    check("ra_valid", {63'b0, valid_M}, 64'd0);
    check("ra_rdata", readData_M, 64'd0);
    reset = 1'b0;
    mem_ready = 1'b1;
    tick();
    check("ra_valid2", {63'b0, valid_M}, 64'd0);
    drive(1'b1, 64'h77, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ra_next_valid", {63'b0, valid_M}, 64'd1);
    check("ra_next_alu", aluResult_M, 64'h77);
    tick();
    $display("reset during access, then alu=0x77 completed");

`ifdef MEM_ALIGN_CHECK_EN
    // ---- misaligned load is rejected without touching memory
    mem_rdata = 64'h1111;
    drive(1'b1, 64'h13, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mis_req_pre", {63'b0, mem_req}, 64'd0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mis_valid", {63'b0, valid_M}, 64'd1);
    check("mis_flag", {63'b0, misalign_M}, 64'd1);
    check("mis_req", {63'b0, mem_req}, 64'd0);
    check("mis_stall", {63'b0, stall_E}, 64'd0);
    check("mis_rdata", readData_M, 64'd0);
    tick();
    check("mis_pulse", {63'b0, misalign_M}, 64'd0);
    check("mis_req2", {63'b0, mem_req}, 64'd0);
    $display("misaligned load addr=0x13 rejected");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter: N, 64, datapath and address width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valid_E  input  1  execute result valid this cycle.
REQ-005 aluResult_E, writeData_E, PCBranch_E  input  N each  execute address/result, store data, branch target.
REQ-006 zero_E, Branch_E, memRead_E, memWrite_E  input  1 each  ALU zero flag and control bits.
REQ-007 stall_E  output  1  upstream SHALL hold all _E inputs while high.
REQ-008 valid_M  output  1  one-cycle pulse; M outputs valid.
REQ-009 aluResult_M, readData_M, PCBranch_M  output  N each  registered result, load data, branch target.
REQ-010 PCSrc_M  output  1  take branch.
REQ-011 mem_req, mem_we  output  1 each  data memory request and write enable.
REQ-012 mem_addr, mem_wdata  output  N each  memory address and store data.
REQ-013 mem_ready  input  1  memory completes the request this cycle.
REQ-014 mem_rdata  input  N  load data, sampled when mem_ready is high.

Function
REQ-015 FSM states SHALL be IDLE and ACCESS.
REQ-016 In IDLE with valid_E=1, all _E fields SHALL be captured into M registers.
REQ-017 On capture, if memRead_E or memWrite_E is set the FSM SHALL go to ACCESS; otherwise it SHALL stay in IDLE and pulse valid_M the next cycle (1-cycle latency).
REQ-018 In ACCESS, mem_req=1, with mem_addr, mem_wdata and mem_we held stable until the cycle mem_ready=1.
REQ-019 On mem_ready in ACCESS: a load SHALL latch mem_rdata into readData_M, then valid_M=1 for one cycle and the FSM returns to IDLE (minimum memory-op latency 2 cycles).
REQ-020 stall_E SHALL be 1 exactly while the state is ACCESS (combinational from state).
REQ-021 valid_E while in ACCESS SHALL be ignored.
REQ-022 If memRead_E and memWrite_E are both set, the op SHALL be a write and readData_M SHALL be unchanged.
REQ-023 PCSrc_M SHALL equal valid_M AND captured Branch AND captured zero.
REQ-024 mem_ready while in IDLE SHALL be ignored.
REQ-025 readData_M SHALL retain its last value across non-load ops.

Reset
REQ-026 While reset=1, state=IDLE and stall_E, valid_M, PCSrc_M, mem_req and mem_we SHALL be 0.
REQ-027 While reset=1, all N-bit M registers SHALL be 0.
REQ-028 Reset during ACCESS SHALL abandon the request, dropping mem_req the cycle after reset is sampled, with no valid_M pulse.

Configuration
REQ-029 Macro MEM_ALIGN_CHECK_EN SHALL control the misalignment check.
REQ-030 When MEM_ALIGN_CHECK_EN is defined, an output misalign_M (1 bit) SHALL be present.
REQ-031 With the check enabled, a memory op whose aluResult_E[2:0] != 0 SHALL NOT enter ACCESS and SHALL NOT assert mem_req.
REQ-032 With the check enabled, such an op SHALL pulse valid_M and misalign_M together next cycle, leaving readData_M unchanged.
REQ-033 Without MEM_ALIGN_CHECK_EN, the misalign_M port SHALL be absent and no alignment check SHALL occur.

Structure
REQ-034 Shared package mem_pkg SHALL hold the state enum (IDLE, ACCESS) and the alignment mask constant.
REQ-035 The M-stage register bank SHALL be one sub-module, flopre (reset plus enable, parameter N), instantiated per field.

Verification
REQ-036 ALU op aluResult_E=0x10, Branch=0 -> valid_M next cycle, aluResult_M=0x10, stall_E never high, mem_req never high.
REQ-037 Load at 0x20, mem_ready tied 1, mem_rdata=0xCAFE -> mem_req for 1 cycle, readData_M=0xCAFE, valid_M 2 cycles after capture.
REQ-038 Store at 0x8 of 0x1234 with mem_ready delayed 3 cycles -> mem_we=1, mem_wdata=0x1234 stable, stall_E high 4 cycles, readData_M unchanged.
REQ-039 Branch_E=1, zero_E=1, PCBranch_E=0x40 -> PCSrc_M=1 and PCBranch_M=0x40 with valid_M; repeat with zero_E=0 -> PCSrc_M=0.
REQ-040 Reset asserted in the second ACCESS cycle -> mem_req=0, stall_E=0, no valid_M; the next ALU op completes normally.
REQ-041 With MEM_ALIGN_CHECK_EN, load at 0x13 -> misalign_M=1 with valid_M, mem_req never asserted.
